// File: rtl/ini_pyld_split_engine_pkg.sv
// Shared head-field layout, FSM encoding and byte-count sizing for the payload splitter.
package ini_pyld_split_engine_pkg;

    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 16;
    localparam int ADDR_LSB = 32;
    localparam int ADDR_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Width able to hold a byte count from 0 to 2*bb-1.
    function automatic int byte_cnt_w(input int bb);
        return $clog2(bb) + 1;
    endfunction

endpackage

// File: rtl/ini_pyld_split_engine_if.sv
// Streaming beat bus carrying a request head alongside packed payload data.
// A beat transfers on a cycle with valid && ready; the master holds valid, head, data and last until then.
interface ini_pyld_split_engine_if #(
    parameter int DATA_W = 256,
    parameter int HEAD_W = 128
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [HEAD_W-1:0] head;
    logic [DATA_W-1:0] data;

    modport master (output valid, last, head, data, input ready);
    modport slave  (input valid, last, head, data, output ready);
endinterface

// File: rtl/pyld_realign_shifter.sv
// Residual byte store plus byte-granular barrel shifter that packs residual and new beat bytes
// into an output beat starting at lane 0.
module pyld_realign_shifter import ini_pyld_split_engine_pkg::*; #(
    parameter int DATA_W = 256,
    localparam int BB = DATA_W / 8,
    localparam int CW = byte_cnt_w(BB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              take,
    input  logic              use_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     in_bytes,
    input  logic [CW-1:0]     need,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     res_cnt
);

    logic [DATA_W-1:0]   res_q;
    logic [CW-1:0]       cnt_q;
    logic [2*DATA_W-1:0] merged;
    logic [DATA_W-1:0]   rest;
    logic [CW-1:0]       total;

    function automatic logic [DATA_W-1:0] keep_low(input logic [DATA_W-1:0] d, input logic [CW-1:0] n);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < BB; i++) begin
            if (i < int'(n)) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    // Residual lanes above cnt_q are always zero, so OR-merging is safe.
    always_comb begin
        merged = {{DATA_W{1'b0}}, res_q};
        if (use_in) begin
            merged = merged | ({{DATA_W{1'b0}}, keep_low(in_data, in_bytes)} << {cnt_q, 3'b000});
        end
        out_data = keep_low(merged[DATA_W-1:0], need);
        rest     = DATA_W'(merged >> {need, 3'b000});
        total    = cnt_q + (use_in ? in_bytes : '0) - need;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            res_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            res_q <= rest;
            cnt_q <= total;
        end
    end

    assign res_cnt = cnt_q;

endmodule

// File: rtl/ini_pyld_split_engine.sv
// Splits a DMA request into sub-packets that never cross a 2^SPLIT_LOG-byte boundary,
// re-packing each sub-packet's payload to start at byte 0 and giving it its own head.
module ini_pyld_split_engine import ini_pyld_split_engine_pkg::*; #(
    parameter int DATA_W    = 256,
    parameter int HEAD_W    = 128,
    parameter int SPLIT_LOG = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ini_pyld_split_engine_if.slave         axis_raw,
    ini_pyld_split_engine_if.master        axis_splited,
    output state_t                         dbg_state
);

    localparam int BB = DATA_W / 8;
    localparam int CW = byte_cnt_w(BB);
    localparam logic [16:0] SPLIT_BYTES = 17'(1) << SPLIT_LOG;

    state_t            state_q, state_d;
    logic [63:0]       cur_addr_q;
    logic [15:0]       rem_q;
    logic [15:0]       in_left_q;
    logic              in_done_q;
    logic [15:0]       chunk_q;
    logic [15:0]       chunk_left_q;
    logic [HEAD_W-1:0] head_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [HEAD_W-1:0] out_head_q;
    logic [DATA_W-1:0] out_data_q;

    logic [CW-1:0]     need;
    logic [CW-1:0]     in_bytes;
    logic [CW-1:0]     res_cnt;
    logic [DATA_W-1:0] pack_data;
    logic              out_free;
    logic              zero_len;
    logic              last_beat;
    logic              raw_ready;
    logic              consume;
    logic              emit;
    logic [16:0]       room;
    logic [15:0]       chunk_calc;
    logic [HEAD_W-1:0] head_calc;
    logic              unused_head_bits;

    assign unused_head_bits = ^{axis_raw.head[HEAD_W-1:ADDR_LSB+ADDR_W], axis_raw.head[ADDR_LSB-1:LEN_W]};

    always_comb begin
        need       = (chunk_left_q >= 16'(BB)) ? CW'(BB) : CW'(chunk_left_q);
        in_bytes   = (in_left_q >= 16'(BB)) ? CW'(BB) : CW'(in_left_q);
        out_free   = !out_valid_q || axis_splited.ready;
        zero_len   = (chunk_left_q == 16'd0);
        last_beat  = (chunk_left_q <= 16'(BB));
        room       = SPLIT_BYTES - 17'(cur_addr_q[SPLIT_LOG-1:0]);
        chunk_calc = ({1'b0, rem_q} < room) ? rem_q : room[15:0];
        head_calc  = '0;
        head_calc[ADDR_LSB +: ADDR_W] = cur_addr_q;
        head_calc[LEN_LSB +: LEN_W]   = chunk_calc;
    end

    // A zero-length request still consumes one beat and emits one empty beat.
    always_comb begin
        state_d   = state_q;
        raw_ready = 1'b0;
        consume   = 1'b0;
        emit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (axis_raw.valid) state_d = ST_CALC;
            end
            ST_CALC: begin
                state_d = in_done_q ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                raw_ready = out_free && !in_done_q && (zero_len || (res_cnt < need));
                consume   = raw_ready && axis_raw.valid;
                emit      = zero_len ? consume : (out_free && ((res_cnt >= need) || consume));
                if (emit && last_beat) state_d = (rem_q != chunk_q) ? ST_CALC : ST_IDLE;
            end
            ST_DRAIN: begin
                emit = out_free && (res_cnt >= need);
                if (emit && last_beat) state_d = (rem_q != chunk_q) ? ST_CALC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q   <= '0;
            rem_q        <= '0;
            in_left_q    <= '0;
            in_done_q    <= 1'b0;
            chunk_q      <= '0;
            chunk_left_q <= '0;
            head_q       <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_head_q   <= '0;
            out_data_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && axis_raw.valid) begin
                cur_addr_q <= axis_raw.head[ADDR_LSB +: ADDR_W];
                rem_q      <= axis_raw.head[LEN_LSB +: LEN_W];
                in_left_q  <= axis_raw.head[LEN_LSB +: LEN_W];
                in_done_q  <= 1'b0;
            end
            if (state_q == ST_CALC) begin
                chunk_q      <= chunk_calc;
                chunk_left_q <= chunk_calc;
                head_q       <= head_calc;
            end
            if (consume) begin
                in_left_q <= in_left_q - 16'(in_bytes);
                if (axis_raw.last || (in_left_q <= 16'(BB))) in_done_q <= 1'b1;
            end
            if (emit) begin
                chunk_left_q <= chunk_left_q - 16'(need);
                out_valid_q  <= 1'b1;
                out_last_q   <= last_beat;
                out_head_q   <= head_q;
                out_data_q   <= pack_data;
                if (last_beat) begin
                    cur_addr_q <= cur_addr_q + 64'(chunk_q);
                    rem_q      <= rem_q - chunk_q;
                end
            end else if (axis_splited.ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    pyld_realign_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == ST_IDLE),
        .take     (emit),
        .use_in   (consume),
        .in_data  (axis_raw.data),
        .in_bytes (in_bytes),
        .need     (need),
        .out_data (pack_data),
        .res_cnt  (res_cnt)
    );

    assign axis_raw.ready     = raw_ready;
    assign axis_splited.valid = out_valid_q;
    assign axis_splited.last  = out_last_q;
    assign axis_splited.head  = out_head_q;
    assign axis_splited.data  = out_data_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_ini_pyld_split_engine.sv
// Bench for the payload splitter: directed and random requests checked against a byte-level split model.
module tb_ini_pyld_split_engine;
    import ini_pyld_split_engine_pkg::*;

    localparam int DATA_W = 256;
    localparam int HEAD_W = 128;
    localparam int BB     = DATA_W / 8;
    localparam int SPLIT  = 4096;
    localparam int EXP_W  = HEAD_W + DATA_W + 1;
    localparam int CHK_W  = EXP_W + 1;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    ini_pyld_split_engine_if #(.DATA_W(DATA_W), .HEAD_W(HEAD_W)) raw_if ();
    ini_pyld_split_engine_if #(.DATA_W(DATA_W), .HEAD_W(HEAD_W)) spl_if ();

    ini_pyld_split_engine #(.DATA_W(DATA_W), .HEAD_W(HEAD_W), .SPLIT_LOG(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axis_raw     (raw_if),
        .axis_splited (spl_if),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [7:0] stim_bytes[$];
    int         out_cnt = 0;
    int         raw_cnt = 0;
    bit         abort = 1'b0;
    bit         held_v = 1'b0;
    logic [EXP_W-1:0] held_vec;

    task automatic chk(input string tag, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [HEAD_W-1:0] mk_head(input logic [63:0] a, input logic [15:0] l);
        return {32'h0, a, 16'h0, l};
    endfunction

    // Reference: walk the request in boundary-limited chunks, byte by byte.
    task automatic model(input logic [63:0] addr, input int len);
        logic [63:0]       a;
        int                r, s, room, c;
        logic [DATA_W-1:0] d;
        a = addr; r = len; s = 0;
        if (len == 0) exp_q.push_back({mk_head(addr, 16'h0), {DATA_W{1'b0}}, 1'b1});
        while (r > 0) begin
            room = SPLIT - int'(a % 64'(SPLIT));
            c = (r < room) ? r : room;
            for (int off = 0; off < c; off += BB) begin
                d = '0;
                for (int i = 0; i < BB; i++) begin
                    if (off + i < c) d[i*8 +: 8] = stim_bytes[s + off + i];
                end
                exp_q.push_back({mk_head(a, 16'(c)), d, (off + BB >= c)});
            end
            a = a + 64'(c);
            r = r - c;
            s = s + c;
        end
    endtask

    always @(negedge clk) begin
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] e;
        act = {spl_if.head, spl_if.data, spl_if.last};
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chk("stall_hold", {spl_if.valid, act}, {1'b1, held_vec});
            if (spl_if.valid && spl_if.ready) begin
                chk("beat_expected", CHK_W'(exp_q.size() != 0), CHK_W'(1));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                chk($sformatf("out_beat%0d", out_cnt), CHK_W'(act), CHK_W'(e));
                out_cnt++;
                held_v = 1'b0;
            end else if (spl_if.valid) begin
                held_v   = 1'b1;
                held_vec = act;
            end else begin
                held_v = 1'b0;
            end
            if (raw_if.valid && raw_if.ready) raw_cnt++;
        end
    end

    task automatic drive(input logic [63:0] addr, input int len, input bit gaps);
        int nb;
        int n;
        bit hs;
        logic [DATA_W-1:0] d;
        nb = (len == 0) ? 1 : (len + BB - 1) / BB;
        raw_if.head = mk_head(addr, 16'(len));
        for (int b = 0; b < nb; b++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                raw_if.valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            for (int i = 0; i < BB; i++) d[i*8 +: 8] = stim_bytes[b*BB + i];
            raw_if.data  = d;
            raw_if.last  = (b == nb - 1);
            raw_if.valid = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && !abort && n < 2000) begin
                @(negedge clk);
                hs = raw_if.ready;
                @(posedge clk); #1;
                n++;
            end
            if (abort) break;
            if (!hs) begin
                chk("in_accept_timeout", CHK_W'(hs), CHK_W'(1));
                break;
            end
        end
        raw_if.valid = 1'b0;
        raw_if.last  = 1'b0;
    endtask

    task automatic make_stim(input int len);
        int nb;
        nb = (len == 0) ? 1 : (len + BB - 1) / BB;
        stim_bytes.delete();
        for (int i = 0; i < nb * BB; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_req(input string tag, input logic [63:0] addr, input int len, input bit bp, input bit gaps);
        int r0;
        int nb;
        nb = (len == 0) ? 1 : (len + BB - 1) / BB;
        make_stim(len);
        model(addr, len);
        r0 = raw_cnt;
        fork
            drive(addr, len, gaps);
            begin
                int n;
                n = 0;
                while (exp_q.size() != 0 && n < 20000) begin
                    spl_if.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(posedge clk); #1;
                    n++;
                end
            end
        join
        spl_if.ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_left"}, CHK_W'(exp_q.size()), CHK_W'(0));
        chk({tag, "_raw_beats"}, CHK_W'(raw_cnt - r0), CHK_W'(nb));
        exp_q.delete();
    endtask

    initial begin
        int base;
        int n;
        raw_if.valid = 1'b0;
        raw_if.last  = 1'b0;
        raw_if.head  = '0;
        raw_if.data  = '0;
        spl_if.ready = 1'b0;

        #12;
        chk("rst_valid", CHK_W'(spl_if.valid), CHK_W'(0));
        chk("rst_last",  CHK_W'(spl_if.last),  CHK_W'(0));
        chk("rst_head",  CHK_W'(spl_if.head),  CHK_W'(0));
        chk("rst_data",  CHK_W'(spl_if.data),  CHK_W'(0));
        chk("rst_raw_ready", CHK_W'(raw_if.ready), CHK_W'(0));
        chk("rst_state", CHK_W'(dbg_state), CHK_W'(ST_IDLE));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        spl_if.ready = 1'b1;

        run_req("aligned", 64'h1000, 256, 1'b0, 1'b0);
        run_req("cross_ff0", 64'h0FF0, 64, 1'b0, 1'b0);
        run_req("three_heads", 64'h0800, 'h2000, 1'b0, 1'b0);
        run_req("three_heads_bp", 64'h0800, 'h2000, 1'b1, 1'b1);
        run_req("len_zero", 64'h40, 0, 1'b0, 1'b0);
        run_req("drain_tail", 64'h0FF0, 20, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            run_req($sformatf("rand%0d", k),
                    64'(k + 3) * 64'(SPLIT) + 64'(SPLIT - $urandom_range(1, 128)),
                    $urandom_range(0, 300), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while the third output beat (second of the second sub-packet) is pending.
        spl_if.ready = 1'b1;
        make_stim(64);
        model(64'h0FF0, 64);
        base  = out_cnt;
        abort = 1'b0;
        fork
            drive(64'h0FF0, 64, 1'b0);
            begin
                n = 0;
                while (out_cnt < base + 2 && n < 200) begin @(posedge clk); #1; n++; end
                chk("mid_rst_reach", CHK_W'(out_cnt - base), CHK_W'(2));
                chk("mid_rst_beat3_pending", CHK_W'(spl_if.valid), CHK_W'(1));
                #1 rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk("mid_rst_valid", CHK_W'(spl_if.valid), CHK_W'(0));
                chk("mid_rst_last",  CHK_W'(spl_if.last),  CHK_W'(0));
                chk("mid_rst_head",  CHK_W'(spl_if.head),  CHK_W'(0));
                chk("mid_rst_data",  CHK_W'(spl_if.data),  CHK_W'(0));
                chk("mid_rst_raw_ready", CHK_W'(raw_if.ready), CHK_W'(0));
                chk("mid_rst_state", CHK_W'(dbg_state), CHK_W'(ST_IDLE));
            end
        join
        exp_q.delete();
        raw_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        abort = 1'b0;
        @(posedge clk); #1;
        run_req("post_rst", 64'h2000, 32, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
